// File: rtl/morse_pattern_player.sv
// Morse-style pattern player: plays a latched 2-bit symbol pattern on a buzzer
// pin as a gated square-wave tone, with one-shot or auto-repeat playback,
// Stop abort, Busy/Done handshake and selectable pin polarity.
module morse_pattern_player #(
  parameter int MAX_SYMBOLS      = 16,
  parameter int UNIT_CYCLES      = 2500000,
  parameter int TONE_HALF_CYCLES = 10000,
  parameter int REPEAT_GAP_UNITS = 7,
  parameter int OUT_ACTIVE_LOW   = 1
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic                                 Start,
  input  logic                                 Stop,
  input  logic                                 Repeat,
  input  logic [2*MAX_SYMBOLS-1:0]             Pattern,
  input  logic [$clog2(MAX_SYMBOLS+1)-1:0]     Pattern_Len,
  output logic                                 Pin_Out,
  output logic                                 Busy,
  output logic                                 Done,
  output logic [$clog2(MAX_SYMBOLS)-1:0]       Sym_Idx
);

  localparam int LEN_W     = $clog2(MAX_SYMBOLS + 1);
  localparam int IDX_W     = $clog2(MAX_SYMBOLS);
  localparam int UC_W      = $clog2(UNIT_CYCLES);
  localparam int TC_W      = (TONE_HALF_CYCLES > 1) ? $clog2(TONE_HALF_CYCLES) : 1;
  localparam int MAX_UNITS = (REPEAT_GAP_UNITS > 3) ? REPEAT_GAP_UNITS : 3;
  localparam int UN_W      = $clog2(MAX_UNITS + 1);
  localparam logic PIN_IDLE = (OUT_ACTIVE_LOW != 0);

  localparam logic [1:0] SYM_END  = 2'b00;
  localparam logic [1:0] SYM_DASH = 2'b10;
  localparam logic [1:0] SYM_GAP  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    TONE,
    SILENCE,
    REP_GAP
  } state_t;

  state_t                 state_q, state_d;
  logic                   done_q, done_d;
  logic [2*MAX_SYMBOLS-1:0] pattern_q;
  logic [LEN_W-1:0]       len_q;
  logic                   repeat_q;
  logic [1:0]             sym_q;
  logic [LEN_W-1:0]       idx_q;
  logic [UC_W-1:0]        unit_cnt_q;
  logic [UN_W-1:0]        units_q;
  logic [TC_W-1:0]        tone_cnt_q;
  logic                   drive_q;
  logic                   pin_q;

  logic [LEN_W-1:0]       len_clamped;
  logic [1:0]             cur_code;
  logic [UN_W-1:0]        target_units;
  logic                   unit_end;
  logic                   phase_done;
  logic                   start_accept;
  logic                   timed_state;
  logic                   drive_eff;

  assign len_clamped  = (Pattern_Len > LEN_W'(MAX_SYMBOLS)) ? LEN_W'(MAX_SYMBOLS) : Pattern_Len;
  // An index equal to MAX_SYMBOLS shifts everything out and reads as the end code.
  assign cur_code     = 2'(pattern_q >> {idx_q, 1'b0});
  assign unit_end     = (unit_cnt_q == UC_W'(UNIT_CYCLES - 1));
  assign phase_done   = unit_end && (units_q == target_units - UN_W'(1));
  assign start_accept = Start && !Stop && (state_q == IDLE);
  assign timed_state  = (state_q == TONE) || (state_q == SILENCE) || (state_q == REP_GAP);
  assign drive_eff    = (state_q == TONE) && drive_q;

  // Length in units of the current timed state.
  always_comb begin
    target_units = UN_W'(1);
    case (state_q)
      TONE:    if (sym_q == SYM_DASH) target_units = UN_W'(3);
      SILENCE: if (sym_q == SYM_GAP)  target_units = UN_W'(2);
      REP_GAP: target_units = UN_W'(REPEAT_GAP_UNITS);
      default: ;
    endcase
  end

  // Next-state and Done decode; Stop overrides everything below it.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          if (len_clamped == '0) done_d  = 1'b1;
          else                   state_d = FETCH;
        end
      end
      FETCH: begin
        if ((idx_q == len_q) || (cur_code == SYM_END)) begin
          if (repeat_q) begin
            state_d = REP_GAP;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else if (cur_code == SYM_GAP) begin
          state_d = SILENCE;
        end else begin
          state_d = TONE;
        end
      end
      TONE:    if (phase_done) state_d = SILENCE;
      SILENCE: if (phase_done) state_d = FETCH;
      REP_GAP: if (phase_done) state_d = FETCH;
      default: state_d = IDLE;
    endcase
    if (Stop) begin
      state_d = IDLE;
      done_d  = (state_q != IDLE);
    end
  end

  // State, latched command, timing counters, tone phase and registered pin.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (RST) begin
      state_q    <= IDLE;
      done_q     <= 1'b0;
      pattern_q  <= '0;
      len_q      <= '0;
      repeat_q   <= 1'b0;
      sym_q      <= SYM_END;
      idx_q      <= '0;
      unit_cnt_q <= '0;
      units_q    <= '0;
      tone_cnt_q <= '0;
      drive_q    <= 1'b0;
      pin_q      <= PIN_IDLE;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;

      if (start_accept) begin
        pattern_q <= Pattern;
        len_q     <= len_clamped;
        repeat_q  <= Repeat;
      end

      if (state_q == FETCH) sym_q <= cur_code;

      if (state_d == IDLE)                              idx_q <= '0;
      else if (state_q == SILENCE && state_d == FETCH)  idx_q <= idx_q + LEN_W'(1);
      else if (state_q == REP_GAP && state_d == FETCH)  idx_q <= '0;

      if (state_d != state_q) begin
        unit_cnt_q <= '0;
        units_q    <= '0;
      end else if (timed_state) begin
        if (unit_end) begin
          unit_cnt_q <= '0;
          units_q    <= units_q + UN_W'(1);
        end else begin
          unit_cnt_q <= unit_cnt_q + UC_W'(1);
        end
      end

      if (state_d == TONE && state_q != TONE) begin
        tone_cnt_q <= '0;
        drive_q    <= 1'b1;
      end else if (state_q == TONE) begin
        if (tone_cnt_q == TC_W'(TONE_HALF_CYCLES - 1)) begin
          tone_cnt_q <= '0;
          drive_q    <= ~drive_q;
        end else begin
          tone_cnt_q <= tone_cnt_q + TC_W'(1);
        end
      end else begin
        drive_q <= 1'b0;
      end

      // Stop silences the pin immediately instead of one cycle later.
      pin_q <= Stop ? PIN_IDLE : (drive_eff ^ PIN_IDLE);
    end
  end

  assign Pin_Out = pin_q;
  assign Busy    = (state_q != IDLE);
  assign Done    = done_q;
  assign Sym_Idx = idx_q[IDX_W-1:0];

endmodule
